// File: rtl/elevator_pkg.sv
// Shared definitions for the elevator call-handling blocks: service direction
// encodings and the width helper used to size floor indices and counters.
package elevator_pkg;

    localparam logic [1:0] DIR_NONE = 2'b00;
    localparam logic [1:0] DIR_UP   = 2'b01;
    localparam logic [1:0] DIR_DOWN = 2'b10;
    localparam logic [1:0] DIR_BOTH = 2'b11;

    // Bits needed to index n items; never less than 1 so ports stay legal.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One push-button channel: two-flop synchroniser, then a level filter that only
// accepts a change after DEBOUNCE consecutive disagreeing samples.
module btn_debounce
    import elevator_pkg::*;
#(
    parameter int DEBOUNCE = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic rise
);

    localparam int                CNT_W    = clog2(DEBOUNCE + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             level_q;
    logic             level_d;
    logic             rise_q;
    logic             rise_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Any sample that agrees with the accepted level restarts the count.
    always_comb begin
        level_d = level_q;
        rise_d  = 1'b0;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = ~level_q;
                rise_d  = ~level_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            level_q <= level_d;
            rise_q  <= rise_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level = level_q;
    assign rise  = rise_q;

endmodule

// File: rtl/call_register.sv
// Elevator call registry: latches debounced button presses as pending calls,
// clears them on service, and reports the longest-waiting floor.
module call_register
    import elevator_pkg::*;
#(
    parameter  int FLOORS   = 8,
    parameter  int DEBOUNCE = 4,
    parameter  int AGE_W    = 8,
    localparam int FLOOR_W  = clog2(FLOORS)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [FLOORS-1:0]  btn_in,
    input  logic [FLOORS-1:0]  btn_up_out,
    input  logic [FLOORS-1:0]  btn_down_out,
    input  logic [FLOORS-1:0]  inactive_in_levels,
    input  logic [FLOORS-1:0]  inactive_out_up_levels,
    input  logic [FLOORS-1:0]  inactive_out_down_levels,
    input  logic               service_valid,
    input  logic [FLOOR_W-1:0] service_floor,
    input  logic [1:0]         service_dir,
    output logic [FLOORS-1:0]  active_in_levels,
    output logic [FLOORS-1:0]  active_out_up_levels,
    output logic [FLOORS-1:0]  active_out_down_levels,
    output logic               any_call,
    output logic [FLOOR_W-1:0] oldest_floor,
    output logic               oldest_valid
);

    localparam logic [FLOOR_W:0]    FLOORS_L = (FLOOR_W + 1)'(FLOORS);
    localparam logic [AGE_W-1:0]    AGE_MAX  = '1;
    // No "up" from the top floor, no "down" from the bottom floor.
    localparam logic [FLOORS-1:0]   UP_MASK  = {1'b0, {(FLOORS - 1){1'b1}}};
    localparam logic [FLOORS-1:0]   DN_MASK  = {{(FLOORS - 1){1'b1}}, 1'b0};

    logic [FLOORS-1:0] rise_in, rise_up, rise_dn;
    logic [FLOORS-1:0] level_in, level_up, level_dn;
    logic [FLOORS-1:0] hit, clr_up, clr_dn, pending;
    logic              svc_ok;

    logic [FLOORS-1:0] in_q, in_d, up_q, up_d, dn_q, dn_d;
    logic [FLOORS-1:0][AGE_W-1:0] age_q, age_d;
    logic [FLOOR_W-1:0] oldest_floor_q, oldest_floor_d;
    logic               oldest_valid_q, oldest_valid_d;

    logic               unused_levels;

    genvar gi;
    generate
        for (gi = 0; gi < FLOORS; gi++) begin : g_floor
            btn_debounce #(.DEBOUNCE(DEBOUNCE)) u_cab (
                .clk(clk), .reset(reset), .raw(btn_in[gi]),
                .level(level_in[gi]), .rise(rise_in[gi])
            );
            btn_debounce #(.DEBOUNCE(DEBOUNCE)) u_up (
                .clk(clk), .reset(reset), .raw(btn_up_out[gi]),
                .level(level_up[gi]), .rise(rise_up[gi])
            );
            btn_debounce #(.DEBOUNCE(DEBOUNCE)) u_dn (
                .clk(clk), .reset(reset), .raw(btn_down_out[gi]),
                .level(level_dn[gi]), .rise(rise_dn[gi])
            );
            assign hit[gi] = svc_ok && (service_floor == FLOOR_W'(gi));
        end
    endgenerate

    assign unused_levels = ^{level_in, level_up, level_dn};

    assign svc_ok  = service_valid && ({1'b0, service_floor} < FLOORS_L);
    assign clr_up  = hit & {FLOORS{service_dir[0]}};
    assign clr_dn  = hit & {FLOORS{service_dir[1]}};
    assign pending = in_q | up_q | dn_q;
    assign any_call = |pending;

    // Clear and disable both dominate a same-cycle set.
    always_comb begin
        in_d = (in_q | rise_in) & ~hit    & ~inactive_in_levels;
        up_d = (up_q | rise_up) & ~clr_up & ~inactive_out_up_levels   & UP_MASK;
        dn_d = (dn_q | rise_dn) & ~clr_dn & ~inactive_out_down_levels & DN_MASK;
    end

    always_comb begin
        for (int i = 0; i < FLOORS; i++) begin
            if (!pending[i]) begin
                age_d[i] = '0;
            end else if (age_q[i] == AGE_MAX) begin
                age_d[i] = AGE_MAX;
            end else begin
                age_d[i] = age_q[i] + 1'b1;
            end
        end
    end

    // Strict greater-than while scanning upward keeps ties on the lowest floor.
    always_comb begin
        logic             found;
        logic [AGE_W-1:0] best_age;
        found          = 1'b0;
        best_age       = '0;
        oldest_floor_d = '0;
        for (int i = 0; i < FLOORS; i++) begin
            if (pending[i] && (!found || (age_q[i] > best_age))) begin
                found          = 1'b1;
                best_age       = age_q[i];
                oldest_floor_d = FLOOR_W'(i);
            end
        end
        oldest_valid_d = any_call;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_q           <= '0;
            up_q           <= '0;
            dn_q           <= '0;
            age_q          <= '0;
            oldest_floor_q <= '0;
            oldest_valid_q <= 1'b0;
        end else begin
            in_q           <= in_d;
            up_q           <= up_d;
            dn_q           <= dn_d;
            age_q          <= age_d;
            oldest_floor_q <= oldest_floor_d;
            oldest_valid_q <= oldest_valid_d;
        end
    end

    assign active_in_levels       = in_q;
    assign active_out_up_levels   = up_q;
    assign active_out_down_levels = dn_q;
    assign oldest_floor           = oldest_floor_q;
    assign oldest_valid           = oldest_valid_q;

endmodule

// File: tb/tb_call_register.sv
// Bench for call_register: a windowed behavioural model checks the default
// instance every cycle; a small 6-floor instance covers saturation and range.
module tb_call_register;
    import elevator_pkg::*;

    localparam int F = 8;
    localparam int D = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Default instance
    logic       reset;
    logic [7:0] btn_in, btn_up, btn_dn, in_in, in_up, in_dn;
    logic       sv;
    logic [2:0] sf;
    logic [1:0] sd;
    logic [7:0] a_in, a_up, a_dn;
    logic       any;
    logic [2:0] oldest;
    logic       ovalid;

    call_register dut_a (
        .clk(clk), .reset(reset),
        .btn_in(btn_in), .btn_up_out(btn_up), .btn_down_out(btn_dn),
        .inactive_in_levels(in_in), .inactive_out_up_levels(in_up),
        .inactive_out_down_levels(in_dn),
        .service_valid(sv), .service_floor(sf), .service_dir(sd),
        .active_in_levels(a_in), .active_out_up_levels(a_up),
        .active_out_down_levels(a_dn), .any_call(any),
        .oldest_floor(oldest), .oldest_valid(ovalid)
    );

    // Small instance: 6 floors, short debounce, 3-bit ages
    logic       reset6;
    logic [5:0] b_in, b_zero;
    logic       b_sv;
    logic [2:0] b_sf;
    logic [1:0] b_sd;
    logic [5:0] b_a_in, b_a_up, b_a_dn;
    logic       b_any;
    logic [2:0] b_old;
    logic       b_ov;

    call_register #(.FLOORS(6), .DEBOUNCE(2), .AGE_W(3)) dut_b (
        .clk(clk), .reset(reset6),
        .btn_in(b_in), .btn_up_out(b_zero), .btn_down_out(b_zero),
        .inactive_in_levels(b_zero), .inactive_out_up_levels(b_zero),
        .inactive_out_down_levels(b_zero),
        .service_valid(b_sv), .service_floor(b_sf), .service_dir(b_sd),
        .active_in_levels(b_a_in), .active_out_up_levels(b_a_up),
        .active_out_down_levels(b_a_dn), .any_call(b_any),
        .oldest_floor(b_old), .oldest_valid(b_ov)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    // ---------------- reference model ----------------
    bit [7:0] m_in, m_up, m_dn;
    int       m_age [F];
    bit [2:0] m_old;
    bit       m_ov;
    bit       m_lvl [3*F];
    bit       m_rise[3*F];
    bit       m_samp[3*F][D+1];   // m_samp[b][k] = raw seen k+1 edges ago

    function automatic bit raw_of(input int b);
        if (b < F)        return btn_in[b];
        else if (b < 2*F) return btn_up[b-F];
        else              return btn_dn[b-2*F];
    endfunction

    task automatic model_reset();
        m_in = '0; m_up = '0; m_dn = '0; m_old = '0; m_ov = 1'b0;
        for (int f = 0; f < F; f++) m_age[f] = 0;
        for (int b = 0; b < 3*F; b++) begin
            m_lvl[b] = 1'b0;
            m_rise[b] = 1'b0;
            for (int k = 0; k <= D; k++) m_samp[b][k] = 1'b0;
        end
    endtask

    task automatic model_step();
        bit [7:0] pend, hit, n_in, n_up, n_dn;
        bit [2:0] n_old;
        int       best;
        bit       all_diff;
        pend  = m_in | m_up | m_dn;
        n_old = '0;
        best  = -1;
        for (int f = 0; f < F; f++)
            if (pend[f] && m_age[f] > best) begin best = m_age[f]; n_old = 3'(f); end
        for (int f = 0; f < F; f++)
            m_age[f] = pend[f] ? ((m_age[f] >= 255) ? 255 : m_age[f] + 1) : 0;
        hit = '0;
        if (sv && int'(sf) < F) hit[sf] = 1'b1;
        for (int f = 0; f < F; f++) begin
            n_in[f] = (m_in[f] | m_rise[f]) & !hit[f] & !in_in[f];
            n_up[f] = (f != F-1) && (m_up[f] | m_rise[F+f]) && !(hit[f] && sd[0]) && !in_up[f];
            n_dn[f] = (f != 0) && (m_dn[f] | m_rise[2*F+f]) && !(hit[f] && sd[1]) && !in_dn[f];
        end
        // A level flips once the synchronised samples of the last D edges all disagree with it.
        for (int b = 0; b < 3*F; b++) begin
            all_diff = 1'b1;
            for (int k = 1; k <= D; k++) if (m_samp[b][k] == m_lvl[b]) all_diff = 1'b0;
            m_rise[b] = 1'b0;
            if (all_diff) begin
                m_lvl[b]  = !m_lvl[b];
                m_rise[b] = m_lvl[b];
            end
            for (int k = D; k >= 1; k--) m_samp[b][k] = m_samp[b][k-1];
            m_samp[b][0] = raw_of(b);
        end
        m_in = n_in; m_up = n_up; m_dn = n_dn;
        m_old = n_old;
        m_ov  = |pend;
    endtask

    task automatic compare_model();
        check("m_in", a_in, m_in);
        check("m_up", a_up, m_up);
        check("m_dn", a_dn, m_dn);
        check("m_any", any, |(m_in | m_up | m_dn));
        check("m_oldest", oldest, m_old);
        check("m_ovalid", ovalid, m_ov);
    endtask

    task automatic step();
        @(posedge clk);
        if (reset) model_reset(); else model_step();
        @(negedge clk);
        compare_model();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        #1;
        check("rst_async_in", a_in | a_up | a_dn, 0);
        step();
        step();
        reset = 1'b0;
    endtask

    // ---------------- table ----------------
    typedef struct {
        logic [7:0] b_in, b_up, b_dn, i_in, i_up, i_dn;
        logic       v;
        logic [2:0] f;
        logic [1:0] d;
        logic [7:0] e_in, e_up, e_dn;
        logic       e_any;
    } vec_t;

    vec_t tbl[13];

    function automatic vec_t mk(input logic [7:0] bi, bu, bd, ii, iu, id,
                                input logic v, input logic [2:0] f, input logic [1:0] d,
                                input logic [7:0] ei, eu, ed, input logic ea);
        vec_t r;
        r.b_in = bi; r.b_up = bu; r.b_dn = bd;
        r.i_in = ii; r.i_up = iu; r.i_dn = id;
        r.v = v; r.f = f; r.d = d;
        r.e_in = ei; r.e_up = eu; r.e_dn = ed; r.e_any = ea;
        return r;
    endfunction

    initial begin
        tbl[0]  = mk(8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 3'd0, DIR_NONE, 8'h01, 8'h00, 8'h00, 1'b1);
        tbl[1]  = mk(8'h00, 8'h80, 8'h01, 8'h00, 8'h00, 8'h00, 1'b0, 3'd0, DIR_NONE, 8'h01, 8'h00, 8'h00, 1'b1);
        tbl[2]  = mk(8'h00, 8'h06, 8'h30, 8'h00, 8'h02, 8'h00, 1'b0, 3'd0, DIR_NONE, 8'h01, 8'h04, 8'h30, 1'b1);
        tbl[3]  = mk(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h10, 1'b0, 3'd0, DIR_NONE, 8'h01, 8'h04, 8'h20, 1'b1);
        tbl[4]  = mk(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 3'd2, DIR_DOWN, 8'h01, 8'h04, 8'h20, 1'b1);
        tbl[5]  = mk(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 3'd2, DIR_UP,   8'h01, 8'h00, 8'h20, 1'b1);
        tbl[6]  = mk(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 3'd5, DIR_BOTH, 8'h01, 8'h00, 8'h00, 1'b1);
        tbl[7]  = mk(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 3'd0, DIR_NONE, 8'h00, 8'h00, 8'h00, 1'b0);
        tbl[8]  = mk(8'h08, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 3'd3, DIR_NONE, 8'h00, 8'h00, 8'h00, 1'b0);
        tbl[9]  = mk(8'h08, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 3'd0, DIR_NONE, 8'h00, 8'h00, 8'h00, 1'b0);
        tbl[10] = mk(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 3'd0, DIR_NONE, 8'h00, 8'h00, 8'h00, 1'b0);
        tbl[11] = mk(8'h08, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 3'd0, DIR_NONE, 8'h08, 8'h00, 8'h00, 1'b1);
        tbl[12] = mk(8'h08, 8'h00, 8'h00, 8'h08, 8'h00, 8'h00, 1'b0, 3'd0, DIR_NONE, 8'h00, 8'h00, 8'h00, 1'b0);
    end

    // ---------------- main sequence ----------------
    logic [7:0] pat_in, pat_up, pat_dn;

    initial begin
        reset = 1'b1; reset6 = 1'b1;
        btn_in = 8'hFF; btn_up = '0; btn_dn = '0;
        in_in = '0; in_up = '0; in_dn = '0;
        sv = 1'b0; sf = '0; sd = DIR_NONE;
        b_in = '0; b_zero = '0; b_sv = 1'b0; b_sf = '0; b_sd = DIR_NONE;
        model_reset();

        // 1: all cabin buttons held through reset
        @(negedge clk);
        compare_model();
        step(); step();
        check("t1_rst_in", a_in, 8'h00);
        check("t1_rst_valid", ovalid, 1'b0);
        reset = 1'b0; reset6 = 1'b0;
        repeat (6) step();
        check("t1_pre_in", a_in, 8'h00);
        step();
        check("t1_set_in", a_in, 8'hFF);
        check("t1_set_any", any, 1'b1);
        check("t1_set_valid", ovalid, 1'b0);
        step();
        check("t1_valid_lag", ovalid, 1'b1);
        check("t1_oldest_tie", oldest, 3'd0);
        $display("t1 reset-held buttons: in=%h valid=%0b", a_in, ovalid);
        btn_in = '0;
        step();
        reset = 1'b1;
        model_reset();
        #1;
        check("t1_async_drop", a_in, 8'h00);
        check("t1_async_any", any, 1'b0);
        step();
        reset = 1'b0;

        // 2: exact latency and short glitch
        btn_up = 8'h10;
        repeat (6) step();
        check("t2_up_pre", a_up, 8'h00);
        step();
        check("t2_up_set", a_up, 8'h10);
        check("t2_any", any, 1'b1);
        repeat (3) step();
        btn_up = '0; btn_in = 8'h04;
        repeat (3) step();
        btn_in = '0;
        repeat (12) step();
        check("t2_glitch", a_in, 8'h00);
        $display("t2 latency/glitch: up=%h in=%h", a_up, a_in);
        do_reset();

        // 3: disable an already pending call
        btn_in = 8'h20;
        repeat (8) step();
        check("t3_pend", a_in, 8'h20);
        in_in = 8'h20;
        step();
        check("t3_inactive", a_in, 8'h00);
        in_in = '0; btn_in = '0;
        repeat (8) step();
        $display("t3 inactive clears pending: in=%h", a_in);
        do_reset();

        // 4: oldest selection and service hand-over
        btn_up = 8'h10;
        repeat (7) step();
        btn_up = '0;
        repeat (5) step();
        btn_in = 8'h02;
        repeat (7) step();
        btn_in = '0;
        check("t4_both", a_in | a_up, 8'h12);
        check("t4_oldest4", oldest, 3'd4);
        sv = 1'b1; sf = 3'd4; sd = DIR_UP;
        step();
        sv = 1'b0;
        check("t4_up_clr", a_up, 8'h00);
        check("t4_oldest_still4", oldest, 3'd4);
        step();
        check("t4_oldest1", oldest, 3'd1);
        $display("t4 oldest hand-over: oldest=%0d in=%h", oldest, a_in);
        do_reset();

        // 5: clear wins over a same-cycle set; other set proceeds
        btn_dn = 8'h08; btn_up = 8'h04;
        repeat (6) step();
        sv = 1'b1; sf = 3'd3; sd = DIR_BOTH;
        step();
        sv = 1'b0;
        check("t5_dn_clear_wins", a_dn, 8'h00);
        check("t5_up_other", a_up, 8'h04);
        repeat (3) step();
        check("t5_dn_stays", a_dn, 8'h00);
        btn_dn = '0; btn_up = '0;
        $display("t5 set/clear collision: dn=%h up=%h", a_dn, a_up);
        do_reset();

        // table vectors
        for (int i = 0; i < 13; i++) begin
            btn_in = tbl[i].b_in; btn_up = tbl[i].b_up; btn_dn = tbl[i].b_dn;
            in_in = tbl[i].i_in; in_up = tbl[i].i_up; in_dn = tbl[i].i_dn;
            sv = tbl[i].v; sf = tbl[i].f; sd = tbl[i].d;
            repeat (10) step();
            check($sformatf("tbl%0d_in", i), a_in, tbl[i].e_in);
            check($sformatf("tbl%0d_up", i), a_up, tbl[i].e_up);
            check($sformatf("tbl%0d_dn", i), a_dn, tbl[i].e_dn);
            check($sformatf("tbl%0d_any", i), any, tbl[i].e_any);
            $display("vec %0d: in=%h up=%h dn=%h any=%0b", i, a_in, a_up, a_dn, any);
        end
        btn_in = '0; btn_up = '0; btn_dn = '0;
        in_in = '0; in_up = '0; in_dn = '0; sv = 1'b0;
        do_reset();

        // randomized transactions against the model
        for (int t = 0; t < 40; t++) begin
            if (t == 20) do_reset();
            pat_in = 8'($urandom) & 8'($urandom);
            pat_up = 8'($urandom) & 8'($urandom);
            pat_dn = 8'($urandom) & 8'($urandom);
            in_in = ($urandom_range(0, 3) == 0) ? 8'($urandom & $urandom & $urandom) : 8'h00;
            in_up = ($urandom_range(0, 3) == 0) ? 8'($urandom & $urandom & $urandom) : 8'h00;
            in_dn = ($urandom_range(0, 3) == 0) ? 8'($urandom & $urandom & $urandom) : 8'h00;
            for (int c = 0; c < 25; c++) begin
                btn_in = pat_in ^ (($urandom_range(0, 7) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00);
                btn_up = pat_up ^ (($urandom_range(0, 7) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00);
                btn_dn = pat_dn ^ (($urandom_range(0, 7) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00);
                sv = ($urandom_range(0, 5) == 0);
                sf = 3'($urandom);
                sd = 2'($urandom);
                step();
            end
            $display("txn %0d: in=%h up=%h dn=%h oldest=%0d valid=%0b",
                     t, a_in, a_up, a_dn, oldest, ovalid);
        end
        btn_in = '0; btn_up = '0; btn_dn = '0;
        in_in = '0; in_up = '0; in_dn = '0; sv = 1'b0;

        // 6: small instance - saturation, out-of-range service, tie, reset mid-debounce
        reset6 = 1'b1; step(); reset6 = 1'b0;
        b_in = 6'h04;
        repeat (4) step();
        check("b_pre", b_a_in, 6'h00);
        step();
        check("b_set", b_a_in, 6'h04);
        repeat (20) step();
        check("b_oldest2", b_old, 3'd2);
        check("b_age_sat", dut_b.age_q[2], 3'd7);
        b_sv = 1'b1; b_sf = 3'd6; b_sd = DIR_BOTH;
        step();
        b_sf = 3'd7;
        step();
        b_sv = 1'b0;
        check("b_svc_oob", b_a_in, 6'h04);
        b_in = 6'h06;
        repeat (5) step();
        check("b_two", b_a_in, 6'h06);
        check("b_oldest_still2", b_old, 3'd2);
        repeat (9) step();
        check("b_tie_low", b_old, 3'd1);
        $display("t6 saturation/tie: in=%h oldest=%0d", b_a_in, b_old);

        b_in = '0;
        reset6 = 1'b1; step(); reset6 = 1'b0;
        b_in = 6'h10;
        repeat (3) step();
        reset6 = 1'b1; b_in = '0;
        step();
        reset6 = 1'b0;
        repeat (10) step();
        check("b_mid_drop", b_a_in, 6'h00);
        b_in = 6'h08;
        repeat (3) step();
        reset6 = 1'b1;
        step();
        reset6 = 1'b0;
        repeat (4) step();
        check("b_held_pre", b_a_in, 6'h00);
        step();
        check("b_held_set", b_a_in, 6'h08);
        $display("t6 reset mid-debounce: in=%h", b_a_in);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
